fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 32-bit instruction ROM. It owns the word-addressed program counter and issues ROM reads under a credit scheme. It buffers the returned words in a small FIFO and hands them to decode over a valid/ready handshake. It handles branch redirects, halts, and end-of-program detection.

---
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: credit-based instruction fetch with PC, FIFO buffer, redirect/halt and end detection.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched/perf_flushed counters.
module fetch_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int ROM_DEPTH  = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       perf_fetched,
    output logic [15:0]       perf_flushed,
`endif
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W:0] END_PC = (ADDR_W+1)'(ROM_DEPTH);
    typedef enum logic [1:0] {FETCH, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_W:0] pc_q, pc_d, pc_inc;
    logic rom_en_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pcs_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic pop, push, credit_ok, issue;
    assign pop       = inst_valid && inst_ready;
    // A word returning during a redirect is the killed in-flight read.
    assign push      = rom_en_q && !redirect_valid;
    assign credit_ok = ({1'b0, cnt_q} + (CW+1)'(rom_en_q) - (CW+1)'(pop)) < (CW+1)'(FIFO_DEPTH);
    assign issue     = (state_q == FETCH) && !halt && !redirect_valid && credit_ok;
    assign pc_inc    = pc_q + (ADDR_W+1)'(1);
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = {1'b0, redirect_addr};
            state_d = ({1'b0, redirect_addr} < END_PC) ? FETCH : DRAIN;
        end else if (issue) begin
            pc_d    = pc_inc;
            state_d = (pc_inc >= END_PC) ? DRAIN : FETCH;
        end else if (state_q == DRAIN && cnt_q == '0 && !rom_en_q) begin
            state_d = DONE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rom_en_q   <= issue;
            rom_addr_q <= issue ? pc_q[ADDR_W-1:0] : rom_addr_q;
            if (redirect_valid) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) begin
                    data_q[wr_q] <= rom_data;
                    pcs_q[wr_q]  <= rom_addr_q;
                    wr_q         <= wr_q + PW'(1);
                end
                if (pop) rd_q <= rd_q + PW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end
    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign inst_valid = cnt_q != '0;
    assign inst_data  = data_q[rd_q];
    assign inst_pc    = pcs_q[rd_q];
    assign done       = state_q == DONE;
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_q, flushed_q;
    logic [16:0] flush_sum;
    assign flush_sum = {1'b0, flushed_q} + 17'(cnt_q) - 17'(pop) + 17'(rom_en_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (pop && fetched_q != 16'hffff) fetched_q <= fetched_q + 16'd1;
            if (redirect_valid) flushed_q <= flush_sum[16] ? 16'hffff : flush_sum[15:0];
        end
    end
    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a sequential-stream fetch model and literal checkpoints.
module tb_fetch_sequencer;
    localparam int AW = 6;
    localparam int RD = 12;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rom_en, inst_valid, inst_ready, redirect_valid, halt, done;
    logic [AW-1:0] rom_addr, inst_pc, redirect_addr;
    logic [31:0] rom_data, inst_data;
    logic [31:0] rom [RD];
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched, perf_flushed;
`endif
    int n_vec = 0, n_err = 0;
    int exp_pc = 0, pops = 0, issues = 0, last_addr = -1;
    bit cond_prev = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int a);
        return (a >= 0 && a < RD) ? rom[a] : 32'hdeadbeef;
    endfunction

    assign rom_data = rom_word(int'(rom_addr));

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
        .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accepted words form a consecutive pc run starting at reset (0) or at the
    // latest redirect target; done follows one edge after the run passes the ROM end.
    always @(posedge clk) begin
        bit p, r, h, hold;
        logic [31:0] hd;
        logic [AW-1:0] hp;
        int ra;
        if (!rst_n) begin
            exp_pc    = 0;
            cond_prev = 1'b0;
        end else begin
            p    = inst_valid && inst_ready;
            r    = redirect_valid;
            h    = halt;
            ra   = int'(redirect_addr);
            hold = inst_valid && !inst_ready && !r;
            hd   = inst_data;
            hp   = inst_pc;
            if (p) begin
                chk("pop_pc", 32'(inst_pc), 32'(exp_pc));
                chk("pop_data", inst_data, rom_word(exp_pc));
                exp_pc++;
                pops++;
            end
            if (r) exp_pc = ra;
            #1;
            if (rom_en) begin
                issues++;
                last_addr = int'(rom_addr);
                chk("addr_range", 32'(rom_addr < RD), 1);
            end
            if (h || r) chk("no_issue", 32'(rom_en), 0);
            if (hold) begin
                chk("hold_valid", 32'(inst_valid), 1);
                chk("hold_data", inst_data, hd);
                chk("hold_pc", 32'(inst_pc), 32'(hp));
            end
            chk("done", 32'(done), 32'((exp_pc >= RD) && cond_prev && !r));
            cond_prev = exp_pc >= RD;
        end
    end

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int max);
        for (int k = 0; k < max && !done; k++) edge_n(1);
        chk("done_timeout", 32'(done), 1);
    endtask

    task automatic do_reset(input logic rdy);
        rst_n = 1'b0;
        inst_ready = rdy;
        halt = 1'b0;
        redirect_valid = 1'b0;
        edge_n(2);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int la, p0;
        rom = '{32'h13a0000c, 32'he3a01004, 32'h33a05000, 32'he3a0200a,
                32'he0813002, 32'he3a03014, 32'he2422001, 32'he3520000,
                32'h1afffffc, 32'he5803000, 32'he3a06007, 32'he1016090};
        inst_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        edge_n(2);
        chk("rst_rom_en", 32'(rom_en), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", 32'(inst_pc), 0);
        chk("rst_done", 32'(done), 0);
        // free run
        @(negedge clk);
        rst_n = 1'b1;
        pops = 0;
        edge_n(1);
        chk("e0_rom_en", 32'(rom_en), 1);
        chk("e0_rom_addr", 32'(rom_addr), 0);
        chk("e0_valid", 32'(inst_valid), 0);
        edge_n(1);
        chk("e1_valid", 32'(inst_valid), 1);
        chk("e1_data", inst_data, 32'h13a0000c);
        chk("e1_pc", 32'(inst_pc), 0);
        edge_n(12);
        chk("free_pops", 32'(pops), 12);
        chk("free_done_early", 32'(done), 0);
        edge_n(1);
        chk("free_done", 32'(done), 1);
        // redirect out of DONE to the last word
        redirect_valid = 1'b1; redirect_addr = 6'd11;
        edge_n(1);
        redirect_valid = 1'b0;
        pops = 0;
        chk("r11_done_low", 32'(done), 0);
        edge_n(1);
        chk("r11_rom_en", 32'(rom_en), 1);
        chk("r11_rom_addr", 32'(rom_addr), 11);
        wait_done(10);
        chk("r11_pops", 32'(pops), 1);
        // redirect out of DONE past the end
        redirect_valid = 1'b1; redirect_addr = 6'd12;
        edge_n(1);
        redirect_valid = 1'b0;
        issues = 0;
        chk("r12_done_low", 32'(done), 0);
        edge_n(1);
        chk("r12_done", 32'(done), 1);
        edge_n(3);
        chk("r12_no_issue", 32'(issues), 0);
        // backpressure from reset
        do_reset(1'b0);
        issues = 0;
        edge_n(6);
        chk("bp_issues", 32'(issues), 2);
        chk("bp_last_addr", 32'(last_addr), 1);
        chk("bp_rom_en", 32'(rom_en), 0);
        chk("bp_data", inst_data, 32'h13a0000c);
        inst_ready = 1'b1;
        edge_n(1);
        inst_ready = 1'b0;
        chk("bp_head_pc1", 32'(inst_pc), 1);
        chk("bp_issue_pc2", 32'(rom_addr), 2);
        // redirect with pc1 buffered, pc2 in flight
        redirect_valid = 1'b1; redirect_addr = 6'd5;
        edge_n(1);
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        chk("rd_flushed_valid", 32'(inst_valid), 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_flushed", 32'(perf_flushed), 2);
        chk("perf_fetched", 32'(perf_fetched), 1);
`endif
        edge_n(1);
        chk("rd_rom_addr", 32'(rom_addr), 5);
        edge_n(1);
        chk("rd_pc5", 32'(inst_pc), 5);
        chk("rd_data5", inst_data, 32'he3a03014);
        // halt mid-stream
        edge_n(3);
        halt = 1'b1;
        p0 = pops;
        edge_n(4);
        chk("halt_drain", 32'(pops > p0), 1);
        la = last_addr;
        halt = 1'b0;
        for (int k = 0; k < 5 && !rom_en; k++) edge_n(1);
        chk("halt_resume_en", 32'(rom_en), 1);
        chk("halt_resume_addr", 32'(rom_addr), 32'(la + 1));
        wait_done(20);
        // async reset with one word buffered and one in flight
        do_reset(1'b0);
        edge_n(2);
        chk("mid_valid_pre", 32'(inst_valid), 1);
        chk("mid_inflight_pre", 32'(rom_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rom_en", 32'(rom_en), 0);
        chk("mid_rom_addr", 32'(rom_addr), 0);
        chk("mid_valid", 32'(inst_valid), 0);
        chk("mid_data", inst_data, 0);
        chk("mid_pc", 32'(inst_pc), 0);
        chk("mid_done", 32'(done), 0);
        do_reset(1'b1);
        edge_n(1);
        chk("restart_addr", 32'(rom_addr), 0);
        edge_n(1);
        chk("restart_pc", 32'(inst_pc), 0);
        chk("restart_data", inst_data, 32'h13a0000c);
        wait_done(30);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
